// File: rtl/uart_tx_cfg_if.sv
// Handshake and serial-line bundle between a frame source and uart_tx_cfg.
interface uart_tx_cfg_if #(
    parameter int unsigned DBIT = 8
);
    logic            tx_start;
    logic            s_tick;
    logic [DBIT-1:0] din;
    logic            tx_ready;
    logic            tx_busy;
    logic            tx_done_tick;
    logic            tx;

    modport master (
        output tx_start, s_tick, din,
        input  tx_ready, tx_busy, tx_done_tick, tx
    );

    modport slave (
        input  tx_start, s_tick, din,
        output tx_ready, tx_busy, tx_done_tick, tx
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register, optional parity
// and one or two stop bits; back-to-back frames leave no idle gap.
module uart_tx_cfg #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned OVS    = 16,
    parameter int unsigned PARITY = 0,
    parameter int unsigned SB     = 1
) (
    input  logic         i_clk,
    input  logic         reset,
    uart_tx_cfg_if.slave bus
);

    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned BW = $clog2(DBIT);

    localparam logic [TW-1:0] TickLast = TW'(OVS - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DBIT - 1);
    localparam logic [BW-1:0] StopLast = BW'(SB - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            accept, tick_end, load;

    assign accept   = bus.tx_start && !hold_full_q;
    assign tick_end = bus.s_tick && (tick_q == TickLast);
    // A frame is loaded from IDLE, or straight out of the last stop tick when data is waiting.
    assign load     = hold_full_q &&
                      ((state_q == StIdle) ||
                       ((state_q == StStop) && tick_end && (bit_q == StopLast)));

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        if (accept) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end

        if ((state_q != StIdle) && bus.s_tick) begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
            end
            StStart: begin
                if (tick_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (tick_end) begin
                    if (bit_q == BitLast) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (tick_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (tick_end) begin
                    if (bit_q == StopLast) begin
                        state_d = StIdle;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d     = StStart;
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ (PARITY == 2);
            hold_full_d = 1'b0;
            tick_d      = '0;
            bit_d       = '0;
            tx_d        = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx_ready     = !hold_full_q;
    assign bus.tx_busy      = (state_q != StIdle);
    assign bus.tx_done_tick = done_q;
    assign bus.tx           = tx_q;

endmodule
